mem_readback: RTL and testbench

- Reverse-direction companion to the serial-to-SDRAM write path: reads a span of 32-bit words from SDRAM and streams them to the FTDI transmit side as bytes.
- Output packet uses the same byte framing as the inbound write packets: command dword (signature + length), then address dword, then pixel dwords, all LSB first.
- Sits between the command decoder (which issues read commands), the SDRAM controller's request/ack port (shared with the display reader) and the FTDI TX byte interface.

---
 rtl/mem_readback_if.sv | 42 ++++
 rtl/mem_readback.sv | 203 ++++++++++++++++++++
 tb/tb_mem_readback.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_readback_if.sv
// Bundles the command, SDRAM read and FTDI TX signals of the readback block.
// master: the readback block itself; slave: the surrounding system / bench.
// Clock and reset stay outside the interface as plain ports.
interface mem_readback_if #(
  parameter int ADDR_W = 25
);
  // Command decoder side
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_len;
  // SDRAM controller request/ack port (shared with the display reader)
  logic              disp_rd_req;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_ack;
  logic              mem_rd_data_valid;
  logic [31:0]       mem_rd_data;
  // FTDI transmit byte stream
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  // Status
  logic              busy;
  logic              err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    input  disp_rd_req, mem_ack, mem_rd_data_valid, mem_rd_data,
    input  tx_ready,
    output cmd_ready, mem_rd_req, mem_rd_addr,
    output tx_data, tx_valid, busy, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    output disp_rd_req, mem_ack, mem_rd_data_valid, mem_rd_data,
    output tx_ready,
    input  cmd_ready, mem_rd_req, mem_rd_addr,
    input  tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/mem_readback.sv
// Reads a span of SDRAM words and streams them out as framed bytes (header, then data LSB first).
// Latency: first header byte is presented the cycle after command acceptance; one byte per cycle max.
// Backpressure: tx_ready low holds the registered byte; disp_rd_req defers new SDRAM requests.
module mem_readback #(
  parameter logic [15:0] CMD_SIGNATURE = 16'hAA55,
  parameter int          ADDR_W        = 25,
  parameter int          TIMEOUT       = 255
) (
  input logic            mem_clk,
  input logic            reset,
  mem_readback_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        byte_q, byte_d;      // byte index within header (0..7) or word (0..3)
  logic [15:0]       len_q, len_d;        // length as sent in the header
  logic [15:0]       words_q, words_d;    // words still to read
  logic [ADDR_W-1:0] addr_q, addr_d;      // next SDRAM word address
  logic [31:0]       shift_q, shift_d;    // word currently being sent
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              req_q, req_d;
  logic [TW-1:0]     tmo_q, tmo_d;        // cycles spent waiting for read data
  logic              err_q, err_d;

  logic              tx_fire;
  logic [31:0]       hdr_addr;

  assign tx_fire  = tx_valid_q & bus.tx_ready;
  assign hdr_addr = 32'(addr_q);

  // Header byte selector: length, signature, then the start address zero-extended to 32 bits.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] len,
                                          input logic [31:0] addr);
    logic [7:0] b;
    case (idx)
      3'd0:    b = len[7:0];
      3'd1:    b = len[15:8];
      3'd2:    b = CMD_SIGNATURE[7:0];
      3'd3:    b = CMD_SIGNATURE[15:8];
      3'd4:    b = addr[7:0];
      3'd5:    b = addr[15:8];
      3'd6:    b = addr[23:16];
      default: b = addr[31:24];
    endcase
    return b;
  endfunction

  // Data byte selector, LSB first.
  function automatic logic [7:0] word_byte(input logic [1:0] idx, input logic [31:0] w);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      len_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      req_q      <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      req_q      <= req_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: header, request, wait for data, send word, repeat.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    len_d      = len_q;
    words_d    = words_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    req_d      = req_q;
    tmo_d      = tmo_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          len_d      = bus.cmd_len;
          words_d    = bus.cmd_len;
          addr_d     = bus.cmd_addr;
          err_d      = 1'b0;
          byte_d     = 3'd0;
          tx_data_d  = bus.cmd_len[7:0];
          tx_valid_d = 1'b1;
          state_d    = S_HDR;
        end
      end

      S_HDR: begin
        if (tx_fire) begin
          if (byte_q == 3'd7) begin
            tx_valid_d = 1'b0;
            byte_d     = 3'd0;
            state_d    = (words_q == 16'd0) ? S_IDLE : S_REQ;
          end else begin
            byte_d    = byte_q + 3'd1;
            tx_data_d = hdr_byte(byte_q + 3'd1, len_q, hdr_addr);
          end
        end
      end

      S_REQ: begin
        // The display reader wins only before our request is raised; once raised it is held to ack.
        if (!req_q) begin
          if (!bus.disp_rd_req) begin
            req_d = 1'b1;
          end
        end else if (bus.mem_ack) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Data beats a simultaneous timeout.
        if (bus.mem_rd_data_valid) begin
          shift_d    = bus.mem_rd_data;
          tx_data_d  = bus.mem_rd_data[7:0];
          tx_valid_d = 1'b1;
          byte_d     = 3'd0;
          state_d    = S_SEND;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          shift_d    = 32'hFFFF_FFFF;
          tx_data_d  = 8'hFF;
          tx_valid_d = 1'b1;
          byte_d     = 3'd0;
          err_d      = 1'b1;
          state_d    = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_SEND: begin
        if (tx_fire) begin
          if (byte_q[1:0] == 2'd3) begin
            tx_valid_d = 1'b0;
            byte_d     = 3'd0;
            words_d    = words_q - 16'd1;
            addr_d     = addr_q + ADDR_W'(1);
            state_d    = (words_q == 16'd1) ? S_IDLE : S_REQ;
          end else begin
            byte_d    = byte_q + 3'd1;
            tx_data_d = word_byte(byte_q[1:0] + 2'd1, shift_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.mem_rd_req  = req_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_readback.sv
// Randomized scoreboard bench for mem_readback: expected bytes/addresses are queued per command
// and consumed by independent TX and SDRAM-responder monitors.
module tb_mem_readback;
  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 255;

  logic mem_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 mem_clk = ~mem_clk;

  mem_readback_if #(.ADDR_W(ADDR_W)) bus ();

  mem_readback #(
    .CMD_SIGNATURE(16'hAA55),
    .ADDR_W       (ADDR_W),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .mem_clk(mem_clk),
    .reset  (reset),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]        exp_bytes[$];
  logic [ADDR_W-1:0] exp_addrs[$];
  bit                tmo_mode = 1'b0;   // responder withholds read data
  int                rdy_mode = 0;      // 0 always ready, 1 toggle, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of the modelled SDRAM.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // TX monitor: owns tx_ready, pops one expected byte per transfer, checks hold under stall.
  initial begin : tx_monitor
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        case (rdy_mode)
          0:       bus.tx_ready = 1'b1;
          1:       bus.tx_ready = ~bus.tx_ready;
          default: bus.tx_ready = ($urandom_range(99) < 60);
        endcase
        if (prev_stall) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_bytes.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tx: got byte %0h expected none at %0t", bus.tx_data, $time);
          end else begin
            check("tx_byte", bus.tx_data, exp_bytes.pop_front());
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
      end
    end
  end

  // SDRAM responder: random ack delay, random data delay, checks request address and stability.
  initial begin : mem_responder
    bit                prev_req = 1'b0;
    bit                acked    = 1'b0;
    int                ack_dly  = -1;
    int                dv_dly   = -1;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       dv_word  = '0;
    bus.mem_ack           = 1'b0;
    bus.mem_rd_data_valid = 1'b0;
    bus.mem_rd_data       = '0;
    forever begin
      @(negedge mem_clk);
      bus.mem_ack           = 1'b0;
      bus.mem_rd_data_valid = 1'b0;
      bus.mem_rd_data       = $urandom;
      if (!reset) begin
        prev_req = 1'b0;
        acked    = 1'b0;
        ack_dly  = -1;
        dv_dly   = -1;
      end else begin
        if (acked) check("req_drop_after_ack", bus.mem_rd_req, 0);
        acked = 1'b0;
        if (dv_dly == 0) begin
          bus.mem_rd_data_valid = 1'b1;
          bus.mem_rd_data       = dv_word;
          dv_dly                = -1;
        end else if (dv_dly > 0) begin
          dv_dly--;
        end
        if (bus.mem_rd_req) begin
          if (!prev_req) begin
            check("req_vs_disp", bus.disp_rd_req, 0);
            req_addr = bus.mem_rd_addr;
            ack_dly  = $urandom_range(6);
            if (exp_addrs.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_req: got addr %0h expected none at %0t", bus.mem_rd_addr, $time);
            end else begin
              check("rd_addr", bus.mem_rd_addr, 32'(exp_addrs.pop_front()));
            end
          end else begin
            check("req_addr_hold", bus.mem_rd_addr, 32'(req_addr));
          end
          if (ack_dly == 0) begin
            bus.mem_ack = 1'b1;
            acked       = 1'b1;
            dv_word     = mem_word(req_addr);
            dv_dly      = tmo_mode ? -1 : int'($urandom_range(5));
          end
          ack_dly--;
        end
        prev_req = bus.mem_rd_req;
      end
    end
  end

  // Issue one command and queue its full expected byte stream and address sequence.
  task automatic issue_cmd(input logic [ADDR_W-1:0] addr, input logic [15:0] len);
    int t = 0;
    @(negedge mem_clk);
    while (!bus.cmd_ready && t < 2000) begin
      @(negedge mem_clk);
      t++;
    end
    check("cmd_ready", bus.cmd_ready, 1);
    exp_bytes.push_back(len[7:0]);
    exp_bytes.push_back(len[15:8]);
    exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hAA);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'((32'(addr)) >> (8 * i)));
    for (int i = 0; i < int'(len); i++) begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       w;
      a = addr + ADDR_W'(i);
      w = tmo_mode ? 32'hFFFF_FFFF : mem_word(a);
      exp_addrs.push_back(a);
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (8 * b)));
    end
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(negedge mem_clk);
    check("accept_busy", bus.busy, 1);
    check("first_byte", {bus.tx_valid, bus.tx_data}, {1'b1, len[7:0]});
    check("err_cleared", bus.err, 0);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Run until idle; optionally throw ignored commands and display-reader contention at the DUT.
  task automatic wait_idle(input int budget, input bit noise, input bit exp_err);
    int t = 0;
    while (t < budget) begin
      @(negedge mem_clk);
      t++;
      #1;
      bus.cmd_valid = 1'b0;
      if (!bus.busy) break;
      if (noise) begin
        bus.disp_rd_req = ($urandom_range(3) == 0);
        if ($urandom_range(9) == 0) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_addr  = ADDR_W'($urandom);
          bus.cmd_len   = 16'($urandom_range(1, 9));
        end
      end
    end
    bus.cmd_valid   = 1'b0;
    bus.disp_rd_req = 1'b0;
    check("done_in_time", bus.busy, 0);
    check("bytes_left", exp_bytes.size(), 0);
    check("addrs_left", exp_addrs.size(), 0);
    check("err_flag", bus.err, 32'(exp_err));
    exp_bytes.delete();
    exp_addrs.delete();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1);
  end

  initial begin : main
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.disp_rd_req = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge mem_clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_req", bus.mem_rd_req, 0);
    check("rst_addr", bus.mem_rd_addr, 0);
    check("rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    check("rst_err", bus.err, 0);
    #1 reset = 1'b1;

    // Basic two-word read, continuous ready.
    rdy_mode = 0;
    issue_cmd(25'h000100, 16'd2);
    wait_idle(500, 1'b0, 1'b0);

    // Zero length at the top address: header only, never a request.
    issue_cmd(25'h1FF_FFFF, 16'd0);
    wait_idle(100, 1'b0, 1'b0);

    // Display reader holds the port for well beyond the header time.
    begin
      int req_seen = 0;
      @(negedge mem_clk);
      #1 bus.disp_rd_req = 1'b1;
      issue_cmd(25'h0ABCDE, 16'd1);
      repeat (30) begin
        @(negedge mem_clk);
        if (bus.mem_rd_req) req_seen++;
      end
      check("req_blocked_by_disp", req_seen, 0);
      #1 bus.disp_rd_req = 1'b0;
      wait_idle(500, 1'b0, 1'b0);
    end

    // tx_ready toggling each cycle, address wrap across the top.
    rdy_mode = 1;
    issue_cmd(25'h1FF_FFFE, 16'd3);
    wait_idle(1000, 1'b0, 1'b0);

    // Read data never returns: all-ones word and sticky error, cleared by the next command.
    rdy_mode = 2;
    tmo_mode = 1'b1;
    issue_cmd(25'h000040, 16'd1);
    wait_idle(1000, 1'b0, 1'b1);
    tmo_mode = 1'b0;
    issue_cmd(25'h000041, 16'd1);
    wait_idle(500, 1'b0, 1'b0);

    // Randomized commands with noise.
    for (int n = 0; n < 30; n++) begin
      logic [ADDR_W-1:0] a;
      logic [15:0]       l;
      a        = ($urandom_range(3) == 0) ? ADDR_W'(25'h1FF_FFFF - $urandom_range(2)) : ADDR_W'($urandom);
      tmo_mode = ($urandom_range(7) == 0);
      l        = tmo_mode ? 16'($urandom_range(1, 2)) : 16'($urandom_range(0, 5));
      rdy_mode = $urandom_range(2);
      issue_cmd(a, l);
      wait_idle(int'(l) * 800 + 200, 1'b1, tmo_mode);
    end
    tmo_mode = 1'b0;

    // Reset in the middle of the data phase, with a command pending during reset.
    rdy_mode = 0;
    issue_cmd(25'h000200, 16'd3);
    begin
      int t = 0;
      while (exp_bytes.size() > 10 && t < 2000) begin
        @(negedge mem_clk);
        t++;
      end
      check("reach_send", exp_bytes.size() <= 10, 1);
    end
    #1;
    reset         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 25'h000300;
    bus.cmd_len   = 16'd4;
    exp_bytes.delete();
    exp_addrs.delete();
    #1;
    check("mid_rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    check("mid_rst_req", {bus.mem_rd_req, 32'(bus.mem_rd_addr)}, 0);
    check("mid_rst_busy", {bus.busy, bus.cmd_ready, bus.err}, 3'b010);
    repeat (3) @(negedge mem_clk);
    #1 bus.cmd_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (40) @(negedge mem_clk);
    check("post_rst_idle", bus.busy, 0);

    // Recovery after reset.
    issue_cmd(25'h000123, 16'd2);
    wait_idle(600, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
